blink_rate_selector: RTL and testbench
======================================

BLINK_RATE_SELECTOR -- requirements
Module: blink_rate_selector

Interface
REQ-001 The block SHALL provide parameter DEBOUNCE_CYCLES, default 250000, the number of consecutive cycles a synced switch level must hold before it is accepted (10 ms at 25 MHz).
REQ-002 The block SHALL provide parameters HALF_PERIOD_0..HALF_PERIOD_3, defaults 12499999, 6249999, 3124999 and 1562499, the terminal counts for blinks of about 1, 2, 4 and 8 Hz.
REQ-003 The block SHALL provide parameter LONG_PRESS_CYCLES, default 25000000, the hold time that counts as a long press (1 s).
REQ-004 Port i_clk, input, 1 bit: the 25 MHz system clock.
REQ-005 Port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port i_switch, input, 1 bit: the raw, asynchronous push-button (1 = pressed).
REQ-007 Port o_half_period, output, 24 bits: the terminal count for the downstream blinker's half-period counter.
REQ-008 Port o_rate_sel, output, 2 bits: the current rate index, 0 to 3.
REQ-009 Port o_rate_change, output, 1 bit: a one-cycle strobe in the cycle after o_half_period or o_rate_sel changes value.
REQ-010 Port o_press, output, 1 bit: a one-cycle pulse on each accepted press.
REQ-011 Port o_long_press, output, 1 bit: a one-cycle pulse on each accepted long press.
REQ-012 Every output SHALL be driven directly from a flip-flop.

Function
REQ-013 i_switch SHALL pass through a two-flop synchronizer before any other logic.
REQ-014 Debounce: a counter SHALL clear whenever the synced level equals the debounced level.
REQ-015 Debounce: otherwise the counter SHALL increment, and when it reaches DEBOUNCE_CYCLES-1 the debounced level SHALL take the synced value and the counter SHALL clear.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level unchanged.
REQ-017 The FSM SHALL have states RATE0 to RATE3, one per rate.
REQ-018 On a debounced rising edge, the FSM SHALL advance RATE0 to RATE1 to RATE2 to RATE3 and wrap back to RATE0.
REQ-019 A debounced falling edge SHALL not change the state.
REQ-020 On a rising edge, o_press SHALL pulse in the cycle after the debounced level rises.
REQ-021 On a rising edge, o_rate_sel and o_half_period SHALL update in that same cycle, and o_rate_change SHALL pulse one cycle later.
REQ-022 o_half_period SHALL always equal HALF_PERIOD_n for the current state n.
REQ-023 Latency from an i_switch step to o_press SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles, within one cycle of synchronizer uncertainty.
REQ-024 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES) bits, and the counter SHALL never wrap.
REQ-025 Only one state advance SHALL occur per debounced rising edge, regardless of how long the switch is held.

Reset
REQ-026 While i_reset is high, state SHALL be RATE0 and o_rate_sel SHALL be 0.
REQ-027 While i_reset is high, o_half_period SHALL be HALF_PERIOD_0.
REQ-028 While i_reset is high, o_press, o_long_press and o_rate_change SHALL be 0.
REQ-029 While i_reset is high, the synchronizer flops, debounced level and all counters SHALL be 0.
REQ-030 Reset asserted mid-debounce or mid-hold SHALL discard the partial count.
REQ-031 If the switch is still held at reset release, it SHALL be accepted as a new press after debounce.

Configuration
REQ-032 With macro BLINK_RATE_LONG_PRESS_EN defined, a hold counter SHALL run while the debounced level is high and clear when it is low.
REQ-033 With BLINK_RATE_LONG_PRESS_EN defined, when the hold counter reaches LONG_PRESS_CYCLES-1, the FSM SHALL go to RATE0 and o_long_press SHALL pulse in the next cycle.
REQ-034 With BLINK_RATE_LONG_PRESS_EN defined, a change of state on a long press SHALL pulse o_rate_change one cycle later, as for any other change.
REQ-035 With BLINK_RATE_LONG_PRESS_EN defined, the hold counter SHALL saturate, so each press gives exactly one long-press event.
REQ-036 Without BLINK_RATE_LONG_PRESS_EN, no hold counter SHALL exist and o_long_press SHALL be tied to 0.

Verification
Benches use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, and HALF_PERIOD_0..3 = 100, 50, 25, 12.
REQ-037 Reset then idle 50 cycles -> o_rate_sel=0, o_half_period=100, all pulse outputs 0.
REQ-038 A 3-cycle high glitch on i_switch -> no o_press, o_rate_sel stays 0.
REQ-039 Four clean presses (10 cycles high, 10 low) -> o_rate_sel 1, 2, 3, 0 and o_half_period 50, 25, 12, 100, one o_press each.
REQ-040 Steady press -> o_press exactly 7 cycles after the i_switch rise (within 1 cycle), o_rate_change one cycle after o_press.
REQ-041 With BLINK_RATE_LONG_PRESS_EN, in RATE2, hold for 40 cycles -> advance to RATE3, then return to RATE0, with one o_long_press and two o_rate_change pulses.
REQ-042 i_reset asserted mid-debounce, released while the switch is held -> o_rate_sel=0, then one press is accepted and o_rate_sel=1.

Source files
------------

// File: rtl/blink_rate_selector.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : blink_rate_selector                                          |
// | Description : Push-button blink-rate selector. Synchronises and debounces  |
// |               a raw switch, steps a four-rate FSM on each accepted press   |
// |               and presents the matching half-period terminal count.        |
// |               Optional macro BLINK_RATE_LONG_PRESS_EN adds a hold counter  |
// |               that returns the selector to rate 0 after a long press.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module blink_rate_selector #(
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter logic [23:0] HALF_PERIOD_0     = 24'd12499999,
    parameter logic [23:0] HALF_PERIOD_1     = 24'd6249999,
    parameter logic [23:0] HALF_PERIOD_2     = 24'd3124999,
    parameter logic [23:0] HALF_PERIOD_3     = 24'd1562499,
    parameter int unsigned LONG_PRESS_CYCLES = 25000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_switch,
    output logic [23:0] o_half_period,
    output logic [1:0]  o_rate_sel,
    output logic        o_rate_change,
    output logic        o_press,
    output logic        o_long_press
);

    // A single-cycle debounce window still needs a one-bit counter.
    localparam int unsigned c_DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_RATE0 = 2'd0;
    localparam logic [1:0] c_RATE1 = 2'd1;
    localparam logic [1:0] c_RATE2 = 2'd2;
    localparam logic [1:0] c_RATE3 = 2'd3;

    // Elaboration-time sanity checks on the timing parameters.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (LONG_PRESS_CYCLES < 2) begin : g_bad_long_press
        $error("LONG_PRESS_CYCLES must be at least 2");
    end

    logic               r_sync_0;
    logic               r_sync_1;
    logic [c_DEB_W-1:0] r_deb_cnt;
    logic               r_deb_level;
    logic               r_deb_prev;
    logic               w_rise;
    logic               w_long;
    logic [1:0]         r_state;
    logic [1:0]         r_state_d;
    logic [1:0]         w_state_nxt;
    logic [23:0]        w_half_nxt;
    logic [23:0]        r_half_period;
    logic               r_press;
    logic               r_rate_change;

    // Two-flop synchroniser for the asynchronous push-button.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync_0 <= 1'b0;
            r_sync_1 <= 1'b0;
        end else begin
            r_sync_0 <= i_switch;
            r_sync_1 <= r_sync_0;
        end
    end

    // Debounce: accept a new level only after it has differed for a full window.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_deb_cnt   <= '0;
            r_deb_level <= 1'b0;
        end else if (r_sync_1 == r_deb_level) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == c_DEB_LAST) begin
            r_deb_level <= r_sync_1;
            r_deb_cnt   <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
        end
    end

    // Delayed debounced level for edge detection.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_deb_prev <= 1'b0;
        end else begin
            r_deb_prev <= r_deb_level;
        end
    end

    // Exactly one cycle of w_rise per accepted press, however long it is held.
    assign w_rise = r_deb_level & ~r_deb_prev;

`ifdef BLINK_RATE_LONG_PRESS_EN
    // Counter saturates one past the trigger value so a hold fires only once.
    localparam int unsigned c_HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_SAT  = c_HOLD_W'(LONG_PRESS_CYCLES);

    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_long_press;

    // Hold counter: runs while the debounced level is high, clears when low.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hold_cnt <= '0;
        end else if (!r_deb_level) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != c_HOLD_SAT) begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
        end
    end

    assign w_long = r_deb_level && (r_hold_cnt == c_HOLD_LAST);

    // Long-press strobe, aligned with the FSM jump back to rate 0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_long_press <= 1'b0;
        end else begin
            r_long_press <= w_long;
        end
    end

    assign o_long_press = r_long_press;
`else
    assign w_long       = 1'b0;
    assign o_long_press = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= c_RATE0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: long press wins over a rising edge.
    always_comb begin
        w_state_nxt = r_state;
        if (w_long) begin
            w_state_nxt = c_RATE0;
        end else if (w_rise) begin
            case (r_state)
                c_RATE0: w_state_nxt = c_RATE1;
                c_RATE1: w_state_nxt = c_RATE2;
                c_RATE2: w_state_nxt = c_RATE3;
                default: w_state_nxt = c_RATE0;
            endcase
        end
    end

    // FSM output decode on the next state so the registered period tracks the state.
    always_comb begin
        w_half_nxt = HALF_PERIOD_0;
        case (w_state_nxt)
            c_RATE0: w_half_nxt = HALF_PERIOD_0;
            c_RATE1: w_half_nxt = HALF_PERIOD_1;
            c_RATE2: w_half_nxt = HALF_PERIOD_2;
            default: w_half_nxt = HALF_PERIOD_3;
        endcase
    end

    // Output registers; the change strobe lags the state update by one cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_half_period <= HALF_PERIOD_0;
            r_press       <= 1'b0;
            r_state_d     <= c_RATE0;
            r_rate_change <= 1'b0;
        end else begin
            r_half_period <= w_half_nxt;
            r_press       <= w_rise;
            r_state_d     <= r_state;
            r_rate_change <= (r_state != r_state_d);
        end
    end

    assign o_half_period = r_half_period;
    assign o_rate_sel    = r_state;
    assign o_press       = r_press;
    assign o_rate_change = r_rate_change;

endmodule
`default_nettype wire

// File: tb/tb_blink_rate_selector.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_blink_rate_selector                                       |
// | Description : Self-checking bench for blink_rate_selector with a          |
// |               window-based reference model and randomized switch traffic. |
// |               Honours BLINK_RATE_LONG_PRESS_EN when defined.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_blink_rate_selector;

    localparam int          c_DEB  = 4;
    localparam int          c_LONG = 20;
`ifdef BLINK_RATE_LONG_PRESS_EN
    localparam bit          c_LP_EN = 1'b1;
`else
    localparam bit          c_LP_EN = 1'b0;
`endif

    logic        i_clk    = 1'b0;
    logic        i_reset  = 1'b0;
    logic        i_switch = 1'b0;
    logic [23:0] o_half_period;
    logic [1:0]  o_rate_sel;
    logic        o_rate_change;
    logic        o_press;
    logic        o_long_press;

    int  total = 0;
    int  bad   = 0;
    bit  check_en = 1'b0;
    int  cnt_press = 0;
    int  cnt_long = 0;
    int  cnt_change = 0;

    blink_rate_selector #(
        .DEBOUNCE_CYCLES  (c_DEB),
        .HALF_PERIOD_0    (24'd100),
        .HALF_PERIOD_1    (24'd50),
        .HALF_PERIOD_2    (24'd25),
        .HALF_PERIOD_3    (24'd12),
        .LONG_PRESS_CYCLES(c_LONG)
    ) u_dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_switch     (i_switch),
        .o_half_period(o_half_period),
        .o_rate_sel   (o_rate_sel),
        .o_rate_change(o_rate_change),
        .o_press      (o_press),
        .o_long_press (o_long_press)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] hp_of(input int rate);
        case (rate)
            0:       return 32'd100;
            1:       return 32'd50;
            2:       return 32'd25;
            default: return 32'd12;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance n clock cycles, leaving time just after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    // Reference model: a level is accepted once the last c_DEB synchronised
    // samples all disagree with the current accepted level; a press is the
    // cycle after acceptance; a long press is a run of c_LONG high cycles.
    int m_win[c_DEB];
    bit m_sw1, m_sw2;
    bit m_deb, m_deb_prev;
    bit m_press, m_long, m_change;
    int m_rate, m_rate_prev, m_hold;

    always @(posedge i_clk) begin : model
        bit s, rise, lng, all_diff, new_deb;
        int new_rate;
        if (i_reset) begin
            for (int i = 0; i < c_DEB; i++) m_win[i] = 0;
            m_sw1 = 0; m_sw2 = 0; m_deb = 0; m_deb_prev = 0;
            m_press = 0; m_long = 0; m_change = 0;
            m_rate = 0; m_rate_prev = 0; m_hold = 0;
        end else begin
            s = m_sw2;
            m_sw2 = m_sw1;
            m_sw1 = i_switch;
            for (int i = c_DEB - 1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = int'(s);
            all_diff = 1'b1;
            for (int i = 0; i < c_DEB; i++) if (m_win[i] == int'(m_deb)) all_diff = 1'b0;
            new_deb  = all_diff ? !m_deb : m_deb;
            rise     = m_deb && !m_deb_prev;
            m_hold   = m_deb ? ((m_hold < c_LONG + 1) ? m_hold + 1 : m_hold) : 0;
            lng      = c_LP_EN && m_deb && (m_hold == c_LONG);
            new_rate = lng ? 0 : (rise ? (m_rate + 1) % 4 : m_rate);
            m_change = (m_rate != m_rate_prev);
            m_rate_prev = m_rate;
            m_rate   = new_rate;
            m_press  = rise;
            m_long   = lng;
            m_deb_prev = m_deb;
            m_deb    = new_deb;
        end
    end

    // Compare process: every falling edge once checking is enabled.
    always @(negedge i_clk) begin
        if (check_en) begin
            if (i_reset) begin
                check("rst_rate_sel", 32'(o_rate_sel), 32'd0);
                check("rst_half_period", 32'(o_half_period), 32'd100);
                check("rst_press", 32'(o_press), 32'd0);
                check("rst_long_press", 32'(o_long_press), 32'd0);
                check("rst_rate_change", 32'(o_rate_change), 32'd0);
            end else begin
                check("rate_sel", 32'(o_rate_sel), 32'(m_rate));
                check("half_period", 32'(o_half_period), hp_of(m_rate));
                check("press", 32'(o_press), 32'(m_press));
                check("long_press", 32'(o_long_press), 32'(m_long));
                check("rate_change", 32'(o_rate_change), 32'(m_change));
            end
        end
    end

    // Pulse counters for the directed scenarios.
    always @(negedge i_clk) begin
        if (!i_reset) begin
            cnt_press  += int'(o_press);
            cnt_long   += int'(o_long_press);
            cnt_change += int'(o_rate_change);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int p0, l0, c0, n;
        int exp_rate[4];
        int exp_hp[4];
        exp_rate = '{1, 2, 3, 0};
        exp_hp   = '{50, 25, 12, 100};

        #1 i_reset = 1'b1;
        cyc(3);
        check_en = 1'b1;
        cyc(2);
        i_reset = 1'b0;

        // Idle after reset.
        cyc(50);
        check("idle_rate_sel", 32'(o_rate_sel), 32'd0);
        check("idle_half_period", 32'(o_half_period), 32'd100);
        check("idle_pulses", 32'(cnt_press + cnt_long + cnt_change), 32'd0);

        // Short glitch must be rejected.
        p0 = cnt_press;
        i_switch = 1'b1;
        cyc(3);
        i_switch = 1'b0;
        cyc(15);
        check("glitch_press", 32'(cnt_press - p0), 32'd0);
        check("glitch_rate_sel", 32'(o_rate_sel), 32'd0);

        // Steady press latency, then the change strobe one cycle later.
        i_switch = 1'b1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge i_clk);
            #1;
            if (o_press) begin
                n = k;
                break;
            end
        end
        if (n < 6 || n > 8) check("press_latency", 32'(n), 32'd7);
        else                check("press_latency", 32'd7, 32'd7 + 32'(n) - 32'(n));
        @(posedge i_clk);
        #1;
        check("change_after_press", 32'(o_rate_change), 32'd1);
        check("rate_after_first_press", 32'(o_rate_sel), 32'd1);
        #1;
        cyc(2);
        i_switch = 1'b0;
        cyc(10);

        // Four clean presses from rate 0.
        i_reset = 1'b1;
        cyc(2);
        i_reset = 1'b0;
        cyc(2);
        p0 = cnt_press;
        for (int k = 0; k < 4; k++) begin
            i_switch = 1'b1;
            cyc(10);
            i_switch = 1'b0;
            cyc(10);
            check("press_rate_sel", 32'(o_rate_sel), 32'(exp_rate[k]));
            check("press_half_period", 32'(o_half_period), 32'(exp_hp[k]));
        end
        check("four_press_count", 32'(cnt_press - p0), 32'd4);
        check("model_rate_pin", 32'(m_rate), 32'd0);

        // Long hold from rate 2.
        repeat (2) begin
            i_switch = 1'b1;
            cyc(10);
            i_switch = 1'b0;
            cyc(10);
        end
        check("pre_hold_rate_sel", 32'(o_rate_sel), 32'd2);
        l0 = cnt_long;
        c0 = cnt_change;
        i_switch = 1'b1;
        cyc(40);
        i_switch = 1'b0;
        cyc(15);
`ifdef BLINK_RATE_LONG_PRESS_EN
        check("hold_long_count", 32'(cnt_long - l0), 32'd1);
        check("hold_change_count", 32'(cnt_change - c0), 32'd2);
        check("hold_rate_sel", 32'(o_rate_sel), 32'd0);
`else
        check("hold_long_count", 32'(cnt_long - l0), 32'd0);
        check("hold_change_count", 32'(cnt_change - c0), 32'd1);
        check("hold_rate_sel", 32'(o_rate_sel), 32'd3);
`endif

        // Reset mid-debounce, switch still held at release.
        i_switch = 1'b1;
        cyc(3);
        i_reset = 1'b1;
        cyc(3);
        check("midreset_rate_sel", 32'(o_rate_sel), 32'd0);
        i_reset = 1'b0;
        p0 = cnt_press;
        cyc(15);
        check("held_release_press", 32'(cnt_press - p0), 32'd1);
        check("held_release_rate_sel", 32'(o_rate_sel), 32'd1);
        i_switch = 1'b0;
        cyc(10);

        // Randomized switch traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                i_reset = 1'b1;
                cyc($urandom_range(1, 2));
                i_reset = 1'b0;
            end
            i_switch = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 12));
        end
        i_switch = 1'b0;
        cyc(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
